// File: rtl/alu_ctrl_stage.sv
// rtl/alu_ctrl_stage.sv - registered ALU-control decode stage with HI/LO multi-cycle sequencer
module alu_ctrl_stage #(
  parameter int CTRL_W      = 5,
  parameter int DIV_CYCLES  = 32,
  parameter int MULT_CYCLES = 1,
  parameter int CNT_W       = $clog2(DIV_CYCLES > MULT_CYCLES ? DIV_CYCLES : MULT_CYCLES) + 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        op,
  input  logic [5:0]        funct,
  input  logic [4:0]        rt,
  input  logic              flush,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [CTRL_W-1:0] alucontrol,
  output logic              out_multicycle,
  output logic              ri_flag,
  output logic              md_busy,
  output logic              md_done
);

  // ALU control codes (local copy of the defines2.vh encodings)
  localparam logic [CTRL_W-1:0] AND_C   = CTRL_W'(5'h00), OR_C    = CTRL_W'(5'h01);
  localparam logic [CTRL_W-1:0] XOR_C   = CTRL_W'(5'h02), NOR_C   = CTRL_W'(5'h03);
  localparam logic [CTRL_W-1:0] ADD_C   = CTRL_W'(5'h04), ADDU_C  = CTRL_W'(5'h05);
  localparam logic [CTRL_W-1:0] SUB_C   = CTRL_W'(5'h06), SUBU_C  = CTRL_W'(5'h07);
  localparam logic [CTRL_W-1:0] SLT_C   = CTRL_W'(5'h08), SLTU_C  = CTRL_W'(5'h09);
  localparam logic [CTRL_W-1:0] SLL_C   = CTRL_W'(5'h0a), SRL_C   = CTRL_W'(5'h0b);
  localparam logic [CTRL_W-1:0] SRA_C   = CTRL_W'(5'h0c), SLLV_C  = CTRL_W'(5'h0d);
  localparam logic [CTRL_W-1:0] SRLV_C  = CTRL_W'(5'h0e), SRAV_C  = CTRL_W'(5'h0f);
  localparam logic [CTRL_W-1:0] LUI_C   = CTRL_W'(5'h10), MFHI_C  = CTRL_W'(5'h11);
  localparam logic [CTRL_W-1:0] MTHI_C  = CTRL_W'(5'h12), MFLO_C  = CTRL_W'(5'h13);
  localparam logic [CTRL_W-1:0] MTLO_C  = CTRL_W'(5'h14), MULT_C  = CTRL_W'(5'h15);
  localparam logic [CTRL_W-1:0] MULTU_C = CTRL_W'(5'h16), DIV_C   = CTRL_W'(5'h17);
  localparam logic [CTRL_W-1:0] DIVU_C  = CTRL_W'(5'h18), USELESS_C = CTRL_W'(5'h1f);

  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, FULL, MC} state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              load;
  logic              div_q;
  logic [CTRL_W-1:0] dec_ctrl;
  logic              dec_ri, dec_mc, dec_div;

  // instruction decode: every path leaves dec_ctrl assigned via the defaults
  always_comb begin
    dec_ctrl = USELESS_C;
    dec_ri   = 1'b0;
    dec_mc   = 1'b0;
    dec_div  = 1'b0;
    case (op)
      6'b000000: begin
        case (funct)
          6'b100000: dec_ctrl = ADD_C;
          6'b100001: dec_ctrl = ADDU_C;
          6'b100010: dec_ctrl = SUB_C;
          6'b100011: dec_ctrl = SUBU_C;
          6'b101010: dec_ctrl = SLT_C;
          6'b101011: dec_ctrl = SLTU_C;
          6'b100100: dec_ctrl = AND_C;
          6'b100111: dec_ctrl = NOR_C;
          6'b100101: dec_ctrl = OR_C;
          6'b100110: dec_ctrl = XOR_C;
          6'b000100: dec_ctrl = SLLV_C;
          6'b000000: dec_ctrl = SLL_C;
          6'b000111: dec_ctrl = SRAV_C;
          6'b000011: dec_ctrl = SRA_C;
          6'b000110: dec_ctrl = SRLV_C;
          6'b000010: dec_ctrl = SRL_C;
          6'b010000: dec_ctrl = MFHI_C;
          6'b010001: dec_ctrl = MTHI_C;
          6'b010010: dec_ctrl = MFLO_C;
          6'b010011: dec_ctrl = MTLO_C;
          6'b001001: dec_ctrl = ADDU_C;  // JALR computes the link address
          6'b011010: begin dec_ctrl = DIV_C;   dec_mc = 1'b1; dec_div = 1'b1; end
          6'b011011: begin dec_ctrl = DIVU_C;  dec_mc = 1'b1; dec_div = 1'b1; end
          6'b011000: begin dec_ctrl = MULT_C;  dec_mc = 1'b1; end
          6'b011001: begin dec_ctrl = MULTU_C; dec_mc = 1'b1; end
          default:   dec_ri = 1'b1;
        endcase
      end
      6'b001000: dec_ctrl = ADD_C;   // ADDI
      6'b001001: dec_ctrl = ADDU_C;  // ADDIU
      6'b001010: dec_ctrl = SLT_C;   // SLTI
      6'b001011: dec_ctrl = SLTU_C;  // SLTIU
      6'b001100: dec_ctrl = AND_C;   // ANDI
      6'b001111: dec_ctrl = LUI_C;   // LUI
      6'b001101: dec_ctrl = OR_C;    // ORI
      6'b001110: dec_ctrl = XOR_C;   // XORI
      6'b100000, 6'b100100, 6'b100001, 6'b100101, 6'b100011,
      6'b101000, 6'b101001, 6'b101011, 6'b000011: dec_ctrl = ADDU_C;  // loads, stores, JAL
      6'b000001: begin
        // only the linking REGIMM branches need the ALU
        if (rt == 5'b10000 || rt == 5'b10001) dec_ctrl = ADDU_C;
      end
      6'b000010, 6'b000100, 6'b000101, 6'b000110, 6'b000111: ;  // J, BEQ, BNE, BLEZ, BGTZ
      default: dec_ri = 1'b1;
    endcase
  end

  assign out_valid = (state == FULL);
  assign md_busy   = (state == MC);
  assign md_done   = (state == MC) && (cnt == '0);
  assign in_ready  = !flush && ((state == IDLE) ||
                                ((state == FULL) && out_ready && !out_multicycle));

  // next-state and counter control; flush overrides everything
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    load    = 1'b0;
    if (flush) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          load    = 1'b1;
          state_n = FULL;
        end
        FULL: if (out_ready) begin
          if (out_multicycle) begin
            state_n = MC;
            cnt_n   = div_q ? DIV_LOAD : MULT_LOAD;
          end else if (in_valid) begin
            load    = 1'b1;
            state_n = FULL;
          end else begin
            state_n = IDLE;
          end
        end
        MC: if (cnt == '0) state_n = IDLE;
            else           cnt_n   = cnt - CNT_W'(1);
        default: state_n = IDLE;
      endcase
    end
  end

  // state and busy counter registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // output pipeline register, loaded on accept
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      alucontrol     <= USELESS_C;
      out_multicycle <= 1'b0;
      ri_flag        <= 1'b0;
      div_q          <= 1'b0;
    end else if (load) begin
      alucontrol     <= dec_ctrl;
      out_multicycle <= dec_mc;
      ri_flag        <= dec_ri;
      div_q          <= dec_div;
    end
  end

endmodule

// File: doc/alu_ctrl_stage.md
Name: alu_ctrl_stage

Overview:
Registered, parametrised successor to the combinational ALU-control decoder. It decodes op/funct/rt into an ALU control code and holds the result in a valid/ready pipeline register between ID and EX. It adds a reserved-instruction flag and a multi-cycle sequencer that blocks issue while DIV/DIVU/MULT/MULTU occupy the HI/LO unit. Control encodings and opcode/funct macros come from defines2.vh.

Parameters:
CTRL_W, 5, width of alucontrol; must hold every *_CONTROL code in defines2.vh.
DIV_CYCLES, 32, EX occupancy of DIV/DIVU in cycles; legal range is >=1.
MULT_CYCLES, 1, EX occupancy of MULT/MULTU in cycles; legal range is >=1.
CNT_W, $clog2(DIV_CYCLES>MULT_CYCLES?DIV_CYCLES:MULT_CYCLES)+1, width of the busy counter (derived).

Ports:
clk  in  1  clock; all state updates on the rising edge
resetn  in  1  asynchronous reset, active low
in_valid  in  1  ID presents an instruction
in_ready  out  1  stage accepts the instruction this cycle
op  in  6  instruction[31:26]
funct  in  6  instruction[5:0]
rt  in  5  instruction[20:16]
flush  in  1  squash the held instruction and abort the busy count
out_ready  in  1  EX can take the held instruction
out_valid  out  1  held instruction is valid
alucontrol  out  CTRL_W  registered control code
out_multicycle  out  1  held instruction is DIV/DIVU/MULT/MULTU
ri_flag  out  1  held instruction is undecodable (reserved-instruction exception)
md_busy  out  1  multi-cycle unit is occupied
md_done  out  1  one-cycle pulse on the final busy cycle

Behaviour:
- Reset (async, resetn=0): state=IDLE; out_valid=0, alucontrol=USELESS_CONTROL, out_multicycle=0, ri_flag=0, md_busy=0, md_done=0, counter=0. Reset mid-count aborts immediately.
- Decode (combinational, registered on accept):
  - R_TYPE funct maps to the matching *_CONTROL: ADD, ADDU, SUB, SUBU, SLT, SLTU, DIV, DIVU, MULT, MULTU, AND, NOR, OR, XOR, SLLV, SLL, SRAV, SRA, SRLV, SRL, MFHI, MTHI, MFLO, MTLO. JALR maps to ADDU_CONTROL.
  - I-type: ADDI->ADD, ADDIU->ADDU, SLTI->SLT, SLTIU->SLTU, ANDI->AND, LUI->LUI, ORI->OR, XORI->XOR.
  - LB/LBU/LH/LHU/LW/SB/SH/SW->ADDU. JAL->ADDU.
  - REGIMM with rt in {BGEZAL, BLTZAL}->ADDU.
  - Any other op, funct or rt gives USELESS_CONTROL. Every path assigns alucontrol, so no latch is inferred.
  - ri_flag=1 only for an unlisted op, or an unlisted funct under R_TYPE. Branches/jumps that need no ALU (BEQ, BNE, J, other REGIMM) give USELESS_CONTROL with ri_flag=0.
- States:
  - IDLE: output register empty.
  - FULL: out_valid=1.
  - MC: counting; out_valid=0, md_busy=1.
- in_ready = !flush && (IDLE || (FULL && out_ready && !out_multicycle)).
- Accept (in_valid && in_ready): register decode outputs; next state FULL.
- FULL, out_ready=1, no new accept:
  - If out_multicycle=0, go to IDLE.
  - If out_multicycle=1, go to MC with counter=DIV_CYCLES-1 (DIV/DIVU) or MULT_CYCLES-1 (MULT/MULTU).
- FULL, out_ready=0: hold all outputs stable; in_ready=0.
- MC: counter decrements each cycle. md_done=1 in the cycle counter==0, then go to IDLE; in_ready returns 1 on the following cycle. A count of 1 gives exactly one MC cycle.
- Flush has priority over everything except reset. Next cycle: state=IDLE, out_valid=0, md_busy=0, counter=0, no md_done. An in_valid in a flush cycle is not accepted.
- Back-to-back single-cycle ops sustain one per cycle with out_ready=1. Latency from accept to out_valid is exactly 1 cycle.

Test Plan:
- Reset then R_TYPE op=000000 funct=100000 (ADD), out_ready=1 -> next cycle out_valid=1, alucontrol=ADD_CONTROL, ri_flag=0; 3 back-to-back ADDs emerge on 3 consecutive cycles.
- op=100011 (LW), out_ready=0 for 4 cycles -> alucontrol=ADDU_CONTROL held stable, in_ready=0 throughout; drains on the cycle out_ready rises.
- DIV (funct=011010), DIV_CYCLES=32, out_ready=1 -> md_busy high 32 cycles, md_done pulses on the 32nd, in_ready=0 until the following cycle.
- op=111111 -> ri_flag=1, alucontrol=USELESS_CONTROL. op=000001 rt=10000 (BLTZAL) -> ADDU_CONTROL, ri_flag=0. op=000100 (BEQ) -> USELESS_CONTROL, ri_flag=0.
- flush at busy cycle 10 of DIV, with in_valid=1 that cycle -> next cycle md_busy=0, out_valid=0, no md_done, input not taken.
- Assert resetn=0 asynchronously mid-FULL -> outputs clear without a clock edge.
